// File: rtl/dice_display_if.sv
// dice_display_if: button/throw pair shared between the dice and its display.
//   button  1  roll button, synchronous to clk
//   throw   3  current dice value, legal range 1..6
// Modports: master drives the pair (dice side), slave observes it (display side).
interface dice_display_if;
    logic       button;
    logic [2:0] throw;

    modport master (output button, output throw);
    modport slave  (input  button, input  throw);
endinterface

// File: rtl/dice_display.sv
// dice_display: consumer end of the electronic dice. Shows live pips while the
// button is held, latches the final throw on release, flags illegal throws
// with a blinking display, counts rolls and detects doubles.
// Ports:
//   clk         in   1      system clock, rising edge
//   rst         in   1      asynchronous active-high reset
//   dice        in   if     slave modport: button, throw
//   leds        out  7      pips: b0 C, b1 TL, b2 TR, b3 ML, b4 MR, b5 BL, b6 BR
//   result      out  3      latched throw
//   done        out  1      one-cycle pulse the cycle after a release
//   err         out  1      high while showing an illegal throw
//   is_double   out  1      latched legal result equals the previous legal one
//   roll_count  out  CNT_W  saturating count of latched throws
module dice_display #(
    parameter int unsigned BLINK_HALF = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    dice_display_if.slave        dice,
    output logic [6:0]           leds,
    output logic [2:0]           result,
    output logic                 done,
    output logic                 err,
    output logic                 is_double,
    output logic [CNT_W-1:0]     roll_count
);

    localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROLLING = 2'd1,
        SHOW    = 2'd2,
        ERROR   = 2'd3
    } state_t;

    state_t             state;
    logic               btn_q;
    logic [2:0]         prev;
    logic [BLINK_W-1:0] blink_cnt;
    logic               release_c;
    logic               legal_c;

    // Pip pattern for a dice value; illegal values light nothing.
    function automatic logic [6:0] decode(input logic [2:0] v);
        logic [6:0] p;
        unique case (v)
            3'd1:    p = 7'h01;
            3'd2:    p = 7'h42;
            3'd3:    p = 7'h43;
            3'd4:    p = 7'h66;
            3'd5:    p = 7'h67;
            3'd6:    p = 7'h7E;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    assign release_c = !dice.button && btn_q;
    assign legal_c   = (dice.throw != 3'd0) && (dice.throw != 3'd7);

    // Display FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            btn_q      <= 1'b0;
            prev       <= 3'd0;
            blink_cnt  <= '0;
            leds       <= 7'h00;
            result     <= 3'd0;
            done       <= 1'b0;
            err        <= 1'b0;
            is_double  <= 1'b0;
            roll_count <= '0;
        end else begin
            btn_q <= dice.button;
            done  <= 1'b0;

            unique case (state)
                IDLE: begin
                    leds <= 7'h00;
                    if (dice.button) begin
                        state <= ROLLING;
                        leds  <= decode(dice.throw);
                    end
                end

                ROLLING: begin
                    leds <= decode(dice.throw);
                    if (release_c) begin
                        result <= dice.throw;
                        done   <= 1'b1;
                        if (roll_count != CNT_MAX) begin
                            roll_count <= roll_count + CNT_W'(1);
                        end
                        if (legal_c) begin
                            state     <= SHOW;
                            is_double <= (dice.throw == prev) && (prev != 3'd0);
                            prev      <= dice.throw;
                        end else begin
                            // Blink starts lit on the very first ERROR cycle.
                            state     <= ERROR;
                            is_double <= 1'b0;
                            err       <= 1'b1;
                            leds      <= 7'h7F;
                            blink_cnt <= '0;
                        end
                    end
                end

                SHOW: begin
                    leds <= decode(result);
                    if (dice.button) begin
                        state <= ROLLING;
                        leds  <= decode(dice.throw);
                    end
                end

                ERROR: begin
                    if (dice.button) begin
                        state     <= ROLLING;
                        err       <= 1'b0;
                        blink_cnt <= '0;
                        leds      <= decode(dice.throw);
                    end else if (blink_cnt == BLINK_LAST) begin
                        blink_cnt <= '0;
                        leds      <= (leds == 7'h00) ? 7'h7F : 7'h00;
                    end else begin
                        blink_cnt <= blink_cnt + BLINK_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dice_display.sv
// tb_dice_display: directed checks of dice_display with an 8-bit and a 2-bit
// roll counter instance fed from the same button/throw stimulus.
module tb_dice_display;

    logic       clk;
    logic       rst;
    logic       btn;
    logic [2:0] thr;

    logic [6:0] leds8,  leds2;
    logic [2:0] result8, result2;
    logic       done8, done2, err8, err2, dbl8, dbl2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    int unsigned n_cmp;
    int unsigned n_bad;

    dice_display_if d8 ();
    dice_display_if d2 ();

    assign d8.button = btn;
    assign d8.throw  = thr;
    assign d2.button = btn;
    assign d2.throw  = thr;

    dice_display #(.BLINK_HALF(4), .CNT_W(8)) u8 (
        .clk(clk), .rst(rst), .dice(d8.slave),
        .leds(leds8), .result(result8), .done(done8), .err(err8),
        .is_double(dbl8), .roll_count(cnt8)
    );

    dice_display #(.BLINK_HALF(4), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .dice(d2.slave),
        .leds(leds2), .result(result2), .done(done2), .err(err2),
        .is_double(dbl2), .roll_count(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are then stable for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Press for two cycles, then release while throw == fin.
    task automatic roll(input logic [2:0] fin);
        btn = 1'b1; thr = 3'd1; step();
        thr = 3'd5; step();
        btn = 1'b0; thr = fin; step();
    endtask

    initial begin
        logic seen_done;
        n_cmp = 0;
        n_bad = 0;
        btn = 1'b0;
        thr = 3'd0;

        // Reset
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        check("rst_leds",   32'(leds8),   32'h00);
        check("rst_result", 32'(result8), 0);
        check("rst_done",   32'(done8),   0);
        check("rst_err",    32'(err8),    0);
        check("rst_dbl",    32'(dbl8),    0);
        check("rst_cnt",    32'(cnt8),    0);
        check("rst_cnt2",   32'(cnt2),    0);

        // Five-cycle roll, throw cycling 1..5, release on 3
        btn = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            thr = 3'(i);
            step();
            if (i == 4) check("live_leds4", 32'(leds8), 32'h66);
            check("roll_no_done", 32'(done8), 0);
        end
        btn = 1'b0; thr = 3'd3; step();
        check("r1_done",   32'(done8),   1);
        check("r1_result", 32'(result8), 3);
        check("r1_leds",   32'(leds8),   32'h43);
        check("r1_cnt",    32'(cnt8),    1);
        check("r1_err",    32'(err8),    0);
        check("r1_dbl",    32'(dbl8),    0);
        step();
        check("r1_done_off", 32'(done8), 0);
        check("r1_hold",     32'(leds8), 32'h43);

        // Double on repeated 3, then a 6
        roll(3'd3);
        check("r2_dbl",  32'(dbl8),  1);
        check("r2_leds", 32'(leds8), 32'h43);
        check("r2_cnt",  32'(cnt8),  2);
        roll(3'd6);
        check("r3_dbl",  32'(dbl8),  0);
        check("r3_leds", 32'(leds8), 32'h7E);
        check("r3_cnt",  32'(cnt8),  3);
        check("r3_cnt2", 32'(cnt2),  3);

        // Illegal throw 7 -> ERROR blink
        roll(3'd7);
        check("e_done",   32'(done8),   1);
        check("e_err",    32'(err8),    1);
        check("e_result", 32'(result8), 7);
        check("e_leds0",  32'(leds8),   32'h7F);
        check("e_dbl",    32'(dbl8),    0);
        check("e_cnt",    32'(cnt8),    4);
        check("e_cnt2_sat",  32'(cnt2),  3);
        check("e_done2",     32'(done2), 1);
        step(); step(); step();
        check("e_leds3", 32'(leds8), 32'h7F);
        step();
        check("e_leds4", 32'(leds8), 32'h00);
        step(); step(); step();
        check("e_leds7", 32'(leds8), 32'h00);
        step();
        check("e_leds8", 32'(leds8), 32'h7F);
        check("e_err_hold", 32'(err8), 1);
        btn = 1'b1; thr = 3'd4; step();
        check("e_exit_err", 32'(err8), 0);
        btn = 1'b0; thr = 3'd6; step();
        check("r5_dbl",   32'(dbl8),  1);
        check("r5_leds",  32'(leds8), 32'h7E);
        check("r5_cnt",   32'(cnt8),  5);
        check("r5_cnt2",  32'(cnt2),  3);
        check("r5_done2", 32'(done2), 1);

        // Button held: no latch
        seen_done = 1'b0;
        btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            thr = 3'(1 + (i % 6));
            step();
            seen_done = seen_done | done8;
        end
        check("held_no_done", 32'(seen_done), 0);
        check("held_cnt",     32'(cnt8),      5);
        btn = 1'b0; thr = 3'd4; step();
        check("held_rel_done", 32'(done8), 1);
        check("held_rel_res",  32'(result8), 4);

        // One-cycle press
        btn = 1'b1; thr = 3'd5; step();
        btn = 1'b0; thr = 3'd2; step();
        check("p1_done",   32'(done8),   1);
        check("p1_result", 32'(result8), 2);
        check("p1_leds",   32'(leds8),   32'h42);
        check("p1_cnt",    32'(cnt8),    7);
        step();
        check("p1_done_off", 32'(done8), 0);

        // Async reset while ROLLING
        btn = 1'b1; thr = 3'd6; step(); step();
        #2 rst = 1'b1;
        #1;
        check("ar_leds", 32'(leds8),   32'h00);
        check("ar_cnt",  32'(cnt8),    0);
        check("ar_res",  32'(result8), 0);
        btn = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Reset while ERROR, then first throw must not be a double
        roll(3'd3);
        check("ar_r1_dbl", 32'(dbl8), 0);
        check("ar_r1_cnt", 32'(cnt8), 1);
        roll(3'd7);
        step(); step();
        check("ae_err_pre", 32'(err8), 1);
        #2 rst = 1'b1;
        #1;
        check("ae_err",  32'(err8),    0);
        check("ae_leds", 32'(leds8),   32'h00);
        check("ae_res",  32'(result8), 0);
        check("ae_cnt",  32'(cnt8),    0);
        step();
        rst = 1'b0;
        step();
        roll(3'd3);
        check("ae_r_dbl",  32'(dbl8),  0);
        check("ae_r_cnt",  32'(cnt8),  1);
        check("ae_r_leds", 32'(leds8), 32'h43);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
